axil_slave_regfile: RTL and testbench
=====================================

// Module: axil_slave_regfile
// PURPOSE
//  AXI-Lite responder (slave endpoint) exposing NUM_REGS word-wide read/write registers.
//  Sits on one slave port of the AXI-Lite interconnect and sees the full system address.
//  Decodes each address relative to BASE_ADDR, services the write and read channels
//  independently, and drives register contents plus per-register write strobes to user logic.
// PARAMETERS
//  AXI_DATA_WIDTH  32        data bus width; must be 32 or 64
//  AXI_ADDR_WIDTH  32        address bus width
//  NUM_REGS        16        register count; power of two, >= 2
//  BASE_ADDR       32'h0     slave base address; equals the interconnect's AXI_ADDR_OFFSET[n]
// PORTS
//  aclk           in   1                     clock
//  areset         in   1                     synchronous reset, active-high
//  s_awaddr       in   AXI_ADDR_WIDTH        write address
//  s_awvalid      in   1                     AW valid
//  s_awready      out  1                     AW ready
//  s_wdata        in   AXI_DATA_WIDTH        write data
//  s_wstrb        in   AXI_DATA_WIDTH/8      byte enables
//  s_wvalid       in   1                     W valid
//  s_wready       out  1                     W ready
//  s_bresp        out  2                     write response
//  s_bvalid       out  1                     B valid
//  s_bready       in   1                     B ready
//  s_araddr       in   AXI_ADDR_WIDTH        read address
//  s_arvalid      in   1                     AR valid
//  s_arready      out  1                     AR ready
//  s_rdata        out  AXI_DATA_WIDTH        read data
//  s_rresp        out  2                     read response
//  s_rvalid       out  1                     R valid
//  s_rready       in   1                     R ready
//  reg_q          out  NUM_REGS*AXI_DATA_WIDTH  flattened register contents; reg i at [i*W +: W]
//  reg_wr_stb     out  NUM_REGS              1-cycle pulse on the cycle register i is updated
// BEHAVIOUR
//  Reset: all registers 0; reg_wr_stb 0; s_bvalid and s_rvalid 0; s_bresp and s_rresp 2'b00;
//   s_rdata 0; s_awready, s_wready and s_arready 1 on the first cycle after reset.
//   Reset mid-transaction drops any pending B/R on the next edge; latched AW/W are discarded.
//  Decode: off = addr - BASE_ADDR (modulo 2^AXI_ADDR_WIDTH).
//   idx = off[$clog2(NUM_REGS)+ADDR_LSB-1 : ADDR_LSB], where ADDR_LSB = $clog2(AXI_DATA_WIDTH/8).
//   Low ADDR_LSB bits are ignored.
//  Write FSM states: WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP.
//   WR_IDLE: awready=wready=1.
//    AW and W handshake in the same cycle -> WR_RESP.
//    Only AW -> WR_HAVE_AW (awready=0); only W -> WR_HAVE_W (wready=0).
//   WR_HAVE_AW / WR_HAVE_W: wait for the missing channel's handshake, then -> WR_RESP.
//   Register update occurs on the edge entering WR_RESP: bytes with wstrb=1 are written,
//    others are kept; reg_wr_stb[idx]=1 for exactly that cycle. bvalid=1 from that same edge.
//   WR_RESP: awready=wready=0; hold bvalid/bresp stable until bready; bvalid&bready -> WR_IDLE.
//   Write-to-B latency: 1 cycle after the later of the AW/W handshakes.
//  Read FSM states: RD_IDLE, RD_RESP.
//   RD_IDLE: arready=1. On handshake, rdata <= reg[idx] and rvalid=1 on the next edge -> RD_RESP.
//   RD_RESP: arready=0; hold rdata/rresp/rvalid until rready; rvalid&rready -> RD_IDLE.
//   One transaction outstanding per channel; back-to-back gives 1 idle cycle between transactions.
//  Simultaneous read and write, same register: if the AR handshake edge equals the write-commit
//   edge, rdata returns the pre-write value; any later AR returns the new value.
//  Write and read FSMs are fully independent; neither blocks the other.
// CONFIGURATION
//  `AXIL_REGFILE_DECERR_EN defined: an access with off >= NUM_REGS*(AXI_DATA_WIDTH/8) is out of range.
//   Out-of-range write: no register change, no reg_wr_stb, bresp=2'b10 (SLVERR).
//   Out-of-range read: rdata=0, rresp=2'b10. The handshake sequence is unchanged.
//  Not defined: no range check; idx aliases modulo NUM_REGS; every bresp/rresp is 2'b00 (OKAY).
// STRUCTURE
//  Shared package axil_pkg gains: typedef enum logic [1:0] axil_resp_t
//   {RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11}.
//  Package supplies the default widths (AXI_DATA_WIDTH, AXI_ADDR_WIDTH); BASE_ADDR is passed
//   per instance from AXI_ADDR_OFFSET.
//  Write and read FSM state enums are local to this module.
//  No sub-module: storage, write FSM and read FSM live in three always_ff blocks in one file.
// TESTING
//  T1 reset: hold areset 3 cycles -> all reg_q=0, bvalid=rvalid=0, awready=wready=arready=1.
//  T2 aligned write: AW+W same cycle, addr=BASE+0x8, data=32'hDEADBEEF, strb=4'hF
//   -> next cycle bvalid=1, bresp=0, reg_wr_stb=16'h0004, reg 2=32'hDEADBEEF.
//  T3 split/partial write: W (data=32'h11223344, strb=4'b0101) 3 cycles before AW (addr=BASE+0x8)
//   -> after T2, reg 2=32'hDE22BE44; bready held low 5 cycles -> bvalid stays 1, B stable.
//  T4 read: AR addr=BASE+0x8 -> rvalid 1 cycle later with rdata=32'hDE22BE44, rresp=0;
//   with rready low 4 cycles, arready=0 throughout and R stays stable.
//  T5 collision: AR and the commit of write 32'h5 to reg 3 on the same edge -> rdata=old reg 3;
//   a second AR returns 32'h5.
//  T6 range: write to BASE+0x40 (NUM_REGS=16).
//   Macro defined -> bresp=2'b10, no reg change; read from BASE+0x40 -> rdata=0, rresp=2'b10.
//   Macro undefined -> reg 0 is written, bresp=0.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite default widths and response codes
package axil_pkg;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_t;
endpackage

// File: rtl/axil_slave_regfile_if.sv
// axil_slave_regfile_if: AXI-Lite bus bundle with master/slave modports
interface axil_slave_regfile_if #(
    parameter int AXI_DATA_WIDTH = axil_pkg::AXI_DATA_WIDTH,
    parameter int AXI_ADDR_WIDTH = axil_pkg::AXI_ADDR_WIDTH
);
    logic [AXI_ADDR_WIDTH-1:0]   s_awaddr;
    logic                        s_awvalid;
    logic                        s_awready;
    logic [AXI_DATA_WIDTH-1:0]   s_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] s_wstrb;
    logic                        s_wvalid;
    logic                        s_wready;
    logic [1:0]                  s_bresp;
    logic                        s_bvalid;
    logic                        s_bready;
    logic [AXI_ADDR_WIDTH-1:0]   s_araddr;
    logic                        s_arvalid;
    logic                        s_arready;
    logic [AXI_DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]                  s_rresp;
    logic                        s_rvalid;
    logic                        s_rready;
    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );
    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI-Lite register file endpoint; AXIL_REGFILE_DECERR_EN enables out-of-range SLVERR
module axil_slave_regfile #(
    parameter int                        AXI_DATA_WIDTH = axil_pkg::AXI_DATA_WIDTH,
    parameter int                        AXI_ADDR_WIDTH = axil_pkg::AXI_ADDR_WIDTH,
    parameter int                        NUM_REGS       = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                               aclk,
    input  logic                               areset,
    axil_slave_regfile_if.slave                s,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                reg_wr_stb
);
    import axil_pkg::*;
    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [1:0] WR_IDLE = 2'd0, WR_HAVE_AW = 2'd1, WR_HAVE_W = 2'd2, WR_RESP = 2'd3;
    localparam logic [0:0] RD_IDLE = 1'b0, RD_RESP = 1'b1;
    logic [1:0]                wr_state;
    logic [0:0]                rd_state;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, wr_addr, wr_off, rd_off;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wr_data;
    logic [BYTES-1:0]          wstrb_q, wr_strb;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok, unused_off;
    assign s.s_awready = wr_state == WR_IDLE || wr_state == WR_HAVE_W;
    assign s.s_wready  = wr_state == WR_IDLE || wr_state == WR_HAVE_AW;
    assign s.s_arready = rd_state == RD_IDLE;
    assign aw_hs  = s.s_awvalid && s.s_awready;
    assign w_hs   = s.s_wvalid && s.s_wready;
    assign ar_hs  = s.s_arvalid && s.s_arready;
    // the write commits on the edge where the later of AW/W completes
    assign commit = (aw_hs || wr_state == WR_HAVE_AW) && (w_hs || wr_state == WR_HAVE_W);
    assign wr_addr = aw_hs ? s.s_awaddr : aw_addr_q;
    assign wr_data = w_hs ? s.s_wdata : wdata_q;
    assign wr_strb = w_hs ? s.s_wstrb : wstrb_q;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign rd_off  = s.s_araddr - BASE_ADDR;
    assign wr_idx  = wr_off[IDX_W+ADDR_LSB-1:ADDR_LSB];
    assign rd_idx  = rd_off[IDX_W+ADDR_LSB-1:ADDR_LSB];
    assign unused_off = ^{wr_off, rd_off};
`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [AXI_ADDR_WIDTH:0] SPAN = (AXI_ADDR_WIDTH+1)'(NUM_REGS * BYTES);
    assign wr_ok = {1'b0, wr_off} < SPAN;
    assign rd_ok = {1'b0, rd_off} < SPAN;
`else
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
`endif
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_stb <= '0;
        end else begin
            reg_wr_stb <= '0;
            if (commit && wr_ok) begin
                reg_wr_stb[wr_idx] <= 1'b1;
                for (int b = 0; b < BYTES; b++)
                    if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state   <= WR_IDLE;
            s.s_bvalid <= 1'b0;
            s.s_bresp  <= RESP_OKAY;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= s.s_awaddr;
            if (w_hs) begin
                wdata_q <= s.s_wdata;
                wstrb_q <= s.s_wstrb;
            end
            if (commit) begin
                wr_state   <= WR_RESP;
                s.s_bvalid <= 1'b1;
                s.s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (aw_hs) begin
                wr_state <= WR_HAVE_AW;
            end else if (w_hs) begin
                wr_state <= WR_HAVE_W;
            end else if (s.s_bvalid && s.s_bready) begin
                wr_state   <= WR_IDLE;
                s.s_bvalid <= 1'b0;
            end
        end
    end
    // non-blocking read of regs returns the pre-write value on a colliding commit edge
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state   <= RD_IDLE;
            s.s_rvalid <= 1'b0;
            s.s_rdata  <= '0;
            s.s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rd_state   <= RD_RESP;
            s.s_rvalid <= 1'b1;
            s.s_rdata  <= rd_ok ? regs[rd_idx] : '0;
            s.s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s.s_rvalid && s.s_rready) begin
            rd_state   <= RD_IDLE;
            s.s_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb_axil_slave_regfile: directed scoreboard bench for the AXI-Lite register file
module tb_axil_slave_regfile;
    import axil_pkg::*;
    localparam logic [31:0] BASE = 32'h4000_1000;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;
    logic          clk = 1'b0;
    logic          rst;
    logic [511:0]  reg_q;
    logic [15:0]   reg_wr_stb;
    logic [15:0]   stb;
    logic [1:0]    b_q[$];
    r_exp_t        r_q[$];
    logic [1:0]    eb;
    r_exp_t        er;
    int            n_cmp = 0;
    int            n_err = 0;
    axil_slave_regfile_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) bif ();
    axil_slave_regfile #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(BASE)
    ) dut (
        .aclk(clk), .areset(rst), .s(bif), .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] rq(input int i);
        return reg_q[i*32 +: 32];
    endfunction
    // monitor: every B/R handshake pops one expected response
    always @(negedge clk) begin
        if (!rst && bif.s_bvalid && bif.s_bready) begin
            if (b_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected: got bresp %h with empty queue", bif.s_bresp);
            end else begin
                eb = b_q.pop_front();
                chk("bresp", 64'(bif.s_bresp), 64'(eb));
            end
        end
        if (!rst && bif.s_rvalid && bif.s_rready) begin
            if (r_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL r_unexpected: got rdata %h with empty queue", bif.s_rdata);
            end else begin
                er = r_q.pop_front();
                chk("rdata", 64'(bif.s_rdata), 64'(er.data));
                chk("rresp", 64'(bif.s_rresp), 64'(er.resp));
            end
        end
    end
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            input logic [1:0] resp, output logic [15:0] stb_o);
        b_q.push_back(resp);
        bif.s_awaddr = a; bif.s_wdata = d; bif.s_wstrb = st;
        bif.s_awvalid = 1'b1; bif.s_wvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0; bif.s_wvalid = 1'b0;
        @(negedge clk);
        stb_o = reg_wr_stb;
        chk("b_latency", 64'(bif.s_bvalid), 64'd1);
        @(posedge clk); #1;
    endtask
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        r_q.push_back('{data: d, resp: resp});
        bif.s_araddr = a; bif.s_arvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_arvalid = 1'b0;
        @(negedge clk);
        chk("r_latency", 64'(bif.s_rvalid), 64'd1);
        @(posedge clk); #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        rst = 1'b1;
        bif.s_awaddr = '0; bif.s_awvalid = 1'b0; bif.s_wdata = '0; bif.s_wstrb = '0;
        bif.s_wvalid = 1'b0; bif.s_bready = 1'b0; bif.s_araddr = '0; bif.s_arvalid = 1'b0;
        bif.s_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_reg_q_zero", 64'(|reg_q), 64'd0);
        chk("t1_stb", 64'(reg_wr_stb), 64'd0);
        chk("t1_bvalid", 64'(bif.s_bvalid), 64'd0);
        chk("t1_rvalid", 64'(bif.s_rvalid), 64'd0);
        chk("t1_ready", 64'({bif.s_awready, bif.s_wready, bif.s_arready}), 64'b111);
        chk("t1_resp_data", 64'({bif.s_bresp, bif.s_rresp, bif.s_rdata}), 64'd0);
        @(posedge clk); #1;
        bif.s_bready = 1'b1;
        do_write(BASE + 32'h8, 32'hDEADBEEF, 4'hF, RESP_OKAY, stb);
        chk("t2_stb", 64'(stb), 64'h0004);
        chk("t2_reg2", 64'(rq(2)), 64'hDEADBEEF);
        chk("t2_stb_pulse", 64'(reg_wr_stb), 64'd0);
        bif.s_bready = 1'b0;
        bif.s_wdata = 32'h11223344; bif.s_wstrb = 4'b0101; bif.s_wvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t3_wready_low", 64'(bif.s_wready), 64'd0);
            chk("t3_awready_high", 64'(bif.s_awready), 64'd1);
            chk("t3_no_b_yet", 64'(bif.s_bvalid), 64'd0);
            @(posedge clk); #1;
        end
        b_q.push_back(RESP_OKAY);
        bif.s_awaddr = BASE + 32'h8; bif.s_awvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0;
        @(negedge clk);
        chk("t3_stb", 64'(reg_wr_stb), 64'h0004);
        chk("t3_reg2", 64'(rq(2)), 64'hDE22BE44);
        repeat (5) begin
            chk("t3_b_hold", 64'({bif.s_bvalid, bif.s_bresp}), 64'b100);
            chk("t3_aw_w_blocked", 64'({bif.s_awready, bif.s_wready}), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bif.s_bready = 1'b1;
        @(posedge clk); #1;
        r_q.push_back('{data: 32'hDE22BE44, resp: RESP_OKAY});
        bif.s_araddr = BASE + 32'h8; bif.s_arvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_arvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_r_hold", 64'({bif.s_rvalid, bif.s_rresp, bif.s_rdata}), {30'd0, 1'b1, 2'b00, 32'hDE22BE44});
            chk("t4_arready_low", 64'(bif.s_arready), 64'd0);
        end
        @(posedge clk); #1;
        bif.s_rready = 1'b1;
        @(posedge clk); #1;
        b_q.push_back(RESP_OKAY);
        r_q.push_back('{data: 32'h0, resp: RESP_OKAY});
        bif.s_awaddr = BASE + 32'hC; bif.s_wdata = 32'h5; bif.s_wstrb = 4'hF;
        bif.s_araddr = BASE + 32'hC;
        bif.s_awvalid = 1'b1; bif.s_wvalid = 1'b1; bif.s_arvalid = 1'b1;
        @(posedge clk); #1;
        bif.s_awvalid = 1'b0; bif.s_wvalid = 1'b0; bif.s_arvalid = 1'b0;
        @(negedge clk);
        chk("t5_stb", 64'(reg_wr_stb), 64'h0008);
        chk("t5_reg3", 64'(rq(3)), 64'h5);
        @(posedge clk); #1;
        do_read(BASE + 32'hC, 32'h5, RESP_OKAY);
        do_read(BASE + 32'hB, 32'hDE22BE44, RESP_OKAY);
`ifdef AXIL_REGFILE_DECERR_EN
        do_write(BASE + 32'h40, 32'hCAFEF00D, 4'hF, RESP_SLVERR, stb);
        chk("t6_stb", 64'(stb), 64'd0);
        chk("t6_reg0", 64'(rq(0)), 64'd0);
        do_read(BASE + 32'h40, 32'h0, RESP_SLVERR);
        do_read(BASE, 32'h0, RESP_OKAY);
`else
        do_write(BASE + 32'h40, 32'hCAFEF00D, 4'hF, RESP_OKAY, stb);
        chk("t6_stb", 64'(stb), 64'h0001);
        chk("t6_reg0", 64'(rq(0)), 64'hCAFEF00D);
        do_read(BASE + 32'h40, 32'hCAFEF00D, RESP_OKAY);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("b_queue_drained", 64'(b_q.size()), 64'd0);
        chk("r_queue_drained", 64'(r_q.size()), 64'd0);
        chk("idle_end", 64'({bif.s_bvalid, bif.s_rvalid}), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
